// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: device-side PS/2 frame transmitter fed from a byte FIFO
module ps2_keyboard_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          tx_done,
  output logic                          tx_abort
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;
  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [10:0]     frame;
  logic [3:0]      bit_idx;
  logic [DW-1:0]   div_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            push, pop, div_end, last_bit;
  assign in_ready = level != LW'(FIFO_DEPTH);
  assign push     = in_valid && in_ready;
  assign div_end  = div_cnt == DW'(CLK_DIV - 1);
  assign last_bit = bit_idx == 4'd10;
  assign pop      = state == LOW && div_end && last_bit;
  assign busy     = state != IDLE || level != '0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level  <= level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      frame    <= '0;
      bit_idx  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        IDLE: if (level != '0 && !inhibit) begin
          frame    <= {1'b1, ~^mem[rd_ptr], mem[rd_ptr], 1'b0};
          bit_idx  <= '0;
          div_cnt  <= '0;
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b0;
          state    <= HIGH;
        end
        HIGH: if (inhibit) begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          tx_abort <= 1'b1;
          gap_cnt  <= '0;
          state    <= GAP;
        end else if (div_end) begin
          div_cnt <= '0;
          ps2_clk <= 1'b0;
          state   <= LOW;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        LOW: if (inhibit && !last_bit) begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          tx_abort <= 1'b1;
          gap_cnt  <= '0;
          state    <= GAP;
        end else if (div_end) begin
          div_cnt  <= '0;
          ps2_clk  <= 1'b1;
          ps2_data <= last_bit ? 1'b1 : frame[bit_idx + 4'd1];
          bit_idx  <= last_bit ? bit_idx : bit_idx + 4'd1;
          tx_done  <= last_bit;
          gap_cnt  <= '0;
          state    <= last_bit ? GAP : HIGH;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
             else gap_cnt <= gap_cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
Device-side PS/2 transmitter. It emulates a keyboard by turning queued scan-code bytes into 11-bit PS/2 frames and driving ps2_clk and ps2_data itself. The bytes arrive on a valid/ready stream and are buffered in an internal FIFO. It is the source end for the team's PS/2 host receiver, used in loopback benches and on-board keyboard emulation.

Parameters:
CLK_DIV, 16, clk cycles per PS/2 clock half-period; legal values are 4 and above.
FIFO_DEPTH, 8, byte FIFO entries; must be a power of 2, 2 or more.
GAP_CYCLES, 32, idle clk cycles forced after every frame, whether completed or aborted.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_data  in  8  scan-code byte to send
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a byte; equals !full
inhibit  in  1  host inhibit (host holding the clock low); blocks or aborts transmission
ps2_clk  out  1  PS/2 clock, registered, idles high
ps2_data  out  1  PS/2 data, registered, idles high
busy  out  1  FSM not in IDLE, or FIFO non-empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
tx_done  out  1  one-cycle pulse when a frame completes
tx_abort  out  1  one-cycle pulse when a frame is aborted by inhibit

Behaviour:
- Reset values: ps2_clk=1, ps2_data=1, in_ready=1, busy=0, level=0, tx_done=0, tx_abort=0; FSM=IDLE; FIFO emptied.
- Reset mid-frame: lines return high on the next edge. The byte in flight and all queued bytes are discarded.
- FIFO push: on in_valid && in_ready.
- FIFO pop: only when a frame completes; the head byte stays in the FIFO for the whole transmission.
- Push and pop in the same cycle: both happen and level is unchanged.
- Full FIFO: in_ready=0 and in_valid is ignored.
- Frame bit order, index 0..10: start=0; D0..D7, LSB first; odd parity (the XOR of the data bits, inverted, so the count of ones in D plus parity is odd); stop=1.
- FSM states: IDLE, HIGH, LOW, GAP.
- IDLE:
  - Both lines high.
  - If the FIFO is non-empty and inhibit=0: latch the frame from the FIFO head, set bit_idx=0, go to HIGH.
  - On that same edge, ps2_data takes bit 0 (0) and ps2_clk stays 1.
- HIGH:
  - ps2_clk=1 and ps2_data=frame[bit_idx], both held for CLK_DIV cycles.
  - Then go to LOW.
- LOW:
  - ps2_clk=0 and ps2_data held, for CLK_DIV cycles.
  - Then, if bit_idx==10: pop the FIFO, pulse tx_done, go to GAP with both lines high.
  - Otherwise: bit_idx+1, go to HIGH, and drive the next bit on that edge.
- Data timing: ps2_data changes only on the rising edge of ps2_clk, so data is stable for CLK_DIV cycles on both sides of each falling edge.
- Frame length: 22*CLK_DIV cycles from the start-bit edge to the line-idle edge.
- GAP: both lines high for GAP_CYCLES, then go to IDLE. inhibit does not stall the gap counter.
- Inhibit while in IDLE or GAP: the FSM holds in IDLE with no frame start.
- Inhibit in HIGH, or in LOW with bit_idx<10:
  - Lines go high on the next edge, tx_abort pulses, FSM goes to GAP.
  - The FIFO is not popped; the same byte is retransmitted in full after inhibit clears.
- Inhibit during LOW of bit 10 is ignored; the frame completes normally.
- Counters: the half-period counter is $clog2(CLK_DIV) bits, the bit index is 4 bits, and the gap counter is wide enough to hold GAP_CYCLES.

Test Plan:
1. CLK_DIV=4: push 0x1C.
   - Falling-edge samples must be 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
   - Frame lasts 88 cycles and tx_done pulses once.
   - Loopback into the host receiver gives data=0x1C with ready pulsing once.
2. Push 0x00, then 0xFF.
   - Parity bit is 1 in both frames.
   - Receiver outputs 0x00 then 0xFF.
   - Idle-to-start spacing between the frames is at least GAP_CYCLES.
3. Hold inhibit=1 and push FIFO_DEPTH+1 bytes (0x01..0x09).
   - After 8 pushes: level=8 and in_ready=0; the 9th byte is dropped and ps2_clk never toggles.
   - Release inhibit: exactly 0x01..0x08 are sent, in order.
4. Push 0xF0 and raise inhibit during HIGH of bit 5.
   - Lines go high next cycle, tx_abort=1, level=1.
   - Release inhibit: a full 0xF0 frame follows, and the receiver sees 0xF0 exactly once.
5. Assert rst during LOW of bit 3 with 3 bytes queued.
   - Next cycle: ps2_clk=1, ps2_data=1, level=0, busy=0.
   - No receiver ready pulse occurs.
6. Push a byte in the same cycle the FIFO pops (level=2 beforehand).
   - level stays 2 and no byte is lost.
